// File: rtl/acb_dram_request_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// acb_dram_request_arbiter_2to1
//
// Round-robin merge of two requester pipes onto the single ACB DRAM request
// pipe, with in-order steering of DRAM responses back to the requester that
// issued each request.
//
// Request side:
//   - A one-entry holding register drives DRAM_REQUEST_*. A new request can
//     be taken whenever the register is empty or is draining this cycle, so
//     back-to-back traffic runs at one request per clock.
//   - On a tie the port that did not win last time is granted.
//   - Every accepted request pushes its port id into a grant-order FIFO.
//     The FIFO depth bounds the number of outstanding requests.
//
// Response side:
//   - Pure combinational pass-through with no storage. The FIFO head selects
//     which RESP port sees the bridge response. A response transfer pops the
//     head.
//   - A bridge response while nothing is outstanding is ignored.
//
// Ports:
//   ui_clk, sys_rst_n                  clock, async active-low reset
//   REQx_pipe_write_req/_ack/_data     requester x request pipe (x = 0,1)
//   RESPx_pipe_read_req/_ack/_data     requester x response pipe
//   DRAM_REQUEST_pipe_write_*          merged request pipe to the bridge
//   DRAM_RESPONSE_pipe_read_*          response pipe from the bridge
//   order_count, order_full            outstanding request count / FIFO full
// -----------------------------------------------------------------------------
module acb_dram_request_arbiter_2to1 #(
  parameter int ORDER_DEPTH = 16,
  parameter int REQ_W       = 110,
  parameter int RESP_W      = 65,
  localparam int PW         = $clog2(ORDER_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic              ui_clk,
  input  logic              sys_rst_n,

  input  logic              REQ0_pipe_write_req,
  output logic              REQ0_pipe_write_ack,
  input  logic [REQ_W-1:0]  REQ0_pipe_write_data,
  input  logic              REQ1_pipe_write_req,
  output logic              REQ1_pipe_write_ack,
  input  logic [REQ_W-1:0]  REQ1_pipe_write_data,

  input  logic              RESP0_pipe_read_req,
  output logic              RESP0_pipe_read_ack,
  output logic [RESP_W-1:0] RESP0_pipe_read_data,
  input  logic              RESP1_pipe_read_req,
  output logic              RESP1_pipe_read_ack,
  output logic [RESP_W-1:0] RESP1_pipe_read_data,

  output logic              DRAM_REQUEST_pipe_write_req,
  input  logic              DRAM_REQUEST_pipe_write_ack,
  output logic [REQ_W-1:0]  DRAM_REQUEST_pipe_write_data,

  output logic              DRAM_RESPONSE_pipe_read_req,
  input  logic              DRAM_RESPONSE_pipe_read_ack,
  input  logic [RESP_W-1:0] DRAM_RESPONSE_pipe_read_data,

  output logic [CW-1:0]     order_count,
  output logic              order_full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(ORDER_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   r_hold_v;
  logic [REQ_W-1:0]       r_hold_d;
  logic                   r_last_grant;
  logic [ORDER_DEPTH-1:0] r_order;       // port id per slot
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;

  // ---------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------
  logic             w_full;
  logic             w_nonempty;
  logic             w_drain;
  logic             w_can_accept;
  logic             w_gnt_v;
  logic             w_gnt_port;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_push;
  logic [REQ_W-1:0] w_push_d;

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);
  assign w_drain    = r_hold_v & DRAM_REQUEST_pipe_write_ack;

  // The full flag comes from the current count. A pop in the same cycle
  // does not open the slot until the next cycle.
  assign w_can_accept = (~r_hold_v | DRAM_REQUEST_pipe_write_ack) & ~w_full;

  // Single request: that port wins. Tie: the port that lost last time wins.
  assign w_gnt_v    = REQ0_pipe_write_req | REQ1_pipe_write_req;
  assign w_gnt_port = (REQ0_pipe_write_req & REQ1_pipe_write_req) ? ~r_last_grant
                                                                  : REQ1_pipe_write_req;

  // Acks are held low while reset is asserted, even though the rest of the
  // path would already allow an accept.
  assign w_ack0 = sys_rst_n & w_can_accept & w_gnt_v & ~w_gnt_port;
  assign w_ack1 = sys_rst_n & w_can_accept & w_gnt_v &  w_gnt_port;
  assign w_push = w_ack0 | w_ack1;
  assign w_push_d = w_gnt_port ? REQ1_pipe_write_data : REQ0_pipe_write_data;

  assign REQ0_pipe_write_ack = w_ack0;
  assign REQ1_pipe_write_ack = w_ack1;

  assign DRAM_REQUEST_pipe_write_req  = r_hold_v;
  assign DRAM_REQUEST_pipe_write_data = r_hold_d;

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold_v     <= 1'b0;
      r_hold_d     <= '0;
      r_last_grant <= 1'b1;          // port0 wins the first tie
    end else begin
      if (w_push) begin
        r_hold_v     <= 1'b1;
        r_hold_d     <= w_push_d;
        r_last_grant <= w_gnt_port;
      end else if (w_drain) begin
        r_hold_v     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response steering
  // ---------------------------------------------------------------------------
  logic w_head;
  logic w_head_req;
  logic w_pop;

  assign w_head     = r_order[r_rptr];
  assign w_head_req = w_head ? RESP1_pipe_read_req : RESP0_pipe_read_req;

  // Only the head port may take a response. The other port stalls even if it
  // is ready, so responses stay in order.
  assign DRAM_RESPONSE_pipe_read_req = w_nonempty & w_head_req;
  assign RESP0_pipe_read_ack = w_nonempty & ~w_head & DRAM_RESPONSE_pipe_read_ack;
  assign RESP1_pipe_read_ack = w_nonempty &  w_head & DRAM_RESPONSE_pipe_read_ack;

  // The error bit rides along untouched. Consumers qualify the data by ack.
  assign RESP0_pipe_read_data = DRAM_RESPONSE_pipe_read_data;
  assign RESP1_pipe_read_data = DRAM_RESPONSE_pipe_read_data;

  assign w_pop = w_nonempty & w_head_req & DRAM_RESPONSE_pipe_read_ack;

  // ---------------------------------------------------------------------------
  // Grant-order FIFO. Pointers wrap naturally because the depth is 2^PW.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_order <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_order[r_wptr] <= w_gnt_port;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign order_count = r_count;
  assign order_full  = w_full;

endmodule

// File: tb/tb_acb_dram_request_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// Self-checking bench for acb_dram_request_arbiter_2to1.
//
// The reference model keeps three things:
//   - a queue of outstanding port ids in grant order,
//   - a queue holding at most one request word still waiting for the bridge,
//   - the last winning port.
// Every cycle the bench drives random inputs between clock edges. It checks
// the DUT outputs against values derived from the model, then advances the
// model by the handshakes that will complete at the next edge.
// -----------------------------------------------------------------------------
module tb_acb_dram_request_arbiter_2to1;

  localparam int DEPTH  = 16;
  localparam int REQ_W  = 110;
  localparam int RESP_W = 65;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, ack0, ack1;
  logic [REQ_W-1:0]  d0, d1;
  logic              rr0, rr1, ra0, ra1;
  logic [RESP_W-1:0] rd0, rd1;
  logic              dq_req, dq_ack;
  logic [REQ_W-1:0]  dq_data;
  logic              ds_req, ds_ack;
  logic [RESP_W-1:0] ds_data;
  logic [CW-1:0]     cnt;
  logic              full;

  acb_dram_request_arbiter_2to1 #(.ORDER_DEPTH(DEPTH), .REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
    .ui_clk                       (clk),
    .sys_rst_n                    (rst_n),
    .REQ0_pipe_write_req          (req0),
    .REQ0_pipe_write_ack          (ack0),
    .REQ0_pipe_write_data         (d0),
    .REQ1_pipe_write_req          (req1),
    .REQ1_pipe_write_ack          (ack1),
    .REQ1_pipe_write_data         (d1),
    .RESP0_pipe_read_req          (rr0),
    .RESP0_pipe_read_ack          (ra0),
    .RESP0_pipe_read_data         (rd0),
    .RESP1_pipe_read_req          (rr1),
    .RESP1_pipe_read_ack          (ra1),
    .RESP1_pipe_read_data         (rd1),
    .DRAM_REQUEST_pipe_write_req  (dq_req),
    .DRAM_REQUEST_pipe_write_ack  (dq_ack),
    .DRAM_REQUEST_pipe_write_data (dq_data),
    .DRAM_RESPONSE_pipe_read_req  (ds_req),
    .DRAM_RESPONSE_pipe_read_ack  (ds_ack),
    .DRAM_RESPONSE_pipe_read_data (ds_data),
    .order_count                  (cnt),
    .order_full                   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  int               m_ord[$];     // outstanding port ids, oldest first
  logic [REQ_W-1:0] m_hold[$];    // request word waiting for the bridge
  int               m_last;       // last winner
  int               max_seen;

  function automatic bit pr(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[REQ_W-1:0];
  endfunction

  task automatic model_reset();
    m_ord.delete();
    m_hold.delete();
    m_last = 1;
  endtask

  // Check the DUT outputs against the model, then advance the model.
  task automatic check_step();
    bit mfull, can, e0, e1, ne, edrq, er0, er1, dq;
    int win, hd;
    mfull = (m_ord.size() == DEPTH);
    can   = ((m_hold.size() == 0) || dq_ack) && !mfull;
    if (req0 && req1) win = 1 - m_last;
    else              win = req1 ? 1 : 0;
    e0   = can && (req0 || req1) && (win == 0);
    e1   = can && (req0 || req1) && (win == 1);
    ne   = (m_ord.size() != 0);
    hd   = ne ? m_ord[0] : 0;
    edrq = ne && ((hd == 1) ? rr1 : rr0);
    er0  = ne && (hd == 0) && ds_ack;
    er1  = ne && (hd == 1) && ds_ack;
    dq   = (m_hold.size() != 0);

    chk("handshakes", {ack0, ack1, ra0, ra1, dq_req, ds_req}, {e0, e1, er0, er1, dq, edrq});
    chk("order_count", cnt, m_ord.size());
    chk("order_full", full, mfull);
    if (dq)  chk("dram_req_data", dq_data, m_hold[0]);
    if (er0) chk("resp0_data", rd0, ds_data);
    if (er1) chk("resp1_data", rd1, ds_data);

    if (dq && dq_ack) void'(m_hold.pop_front());
    if (edrq && ds_ack) void'(m_ord.pop_front());
    if (e0 || e1) begin
      m_hold.push_back(e0 ? d0 : d1);
      m_ord.push_back(win);
      m_last = win;
    end
    if (m_ord.size() > max_seen) max_seen = m_ord.size();
  endtask

  // Per-cycle percentages: port reqs, bridge request ack,
  // bridge response ack, RESP port readiness.
  task automatic cycle(input int p_req, input int p_dqa, input int p_dsa, input int p_rr);
    @(posedge clk); #1;
    req0    = pr(p_req);
    req1    = pr(p_req);
    d0      = rnd_req();
    d1      = rnd_req();
    dq_ack  = pr(p_dqa);
    ds_ack  = pr(p_dsa);
    ds_data = {$urandom_range(1, 0), $urandom, $urandom};
    rr0     = pr(p_rr);
    rr1     = pr(p_rr);
    #1;
    check_step();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; d0 = '0; d1 = '0; rr0 = 0; rr1 = 0;
    dq_ack = 0; ds_ack = 0; ds_data = '0;
  endtask

  initial begin
    max_seen = 0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    // Reset state. Acks stay low even when every input asks for a transfer.
    req0 = 1; req1 = 1; ds_ack = 1; rr0 = 1; rr1 = 1; dq_ack = 1;
    #1;
    chk("rst_handshakes", {ack0, ack1, ra0, ra1, dq_req, ds_req}, 6'b0);
    chk("rst_count", cnt, 0);
    chk("rst_data", dq_data, 0);
    idle_inputs();
    @(posedge clk); #1 rst_n = 1'b1;

    repeat (150) cycle(50, 60, 40, 70);   // mixed traffic
    repeat (60)  cycle(100, 100, 100, 100); // full throughput, alternating grants
    repeat (60)  cycle(70, 80, 0, 50);     // no responses: fill to full
    chk("reached_full", max_seen, DEPTH);
    repeat (60)  cycle(80, 100, 30, 60);   // drain one at a time from full
    repeat (40)  cycle(90, 0, 50, 80);     // bridge stalls the request pipe
    repeat (150) cycle(50, 60, 50, 50);

    // Reset in the middle of traffic. Outputs must clear immediately.
    @(posedge clk); #1;
    req0 = 1; req1 = 1; dq_ack = 1; ds_ack = 1; rr0 = 1; rr1 = 1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_handshakes", {ack0, ack1, ra0, ra1, dq_req, ds_req}, 6'b0);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_full", full, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    idle_inputs();

    repeat (200) cycle(60, 70, 50, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
